// File: rtl/csa_accum_sequencer.sv
// Carry-save accumulation sequencer: folds one streamed operand per cycle through a
// single row of 3:2 compressors and presents the redundant and resolved result.
module csa_accum_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MAX_OPS = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [$clog2(MAX_OPS+1)-1:0]       num_ops,
    input  logic                               op_valid,
    output logic                               op_ready,
    input  logic [WIDTH-1:0]                   op_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_sum,
    output logic [WIDTH-1:0]                   out_carry,
    output logic [WIDTH-1:0]                   out_total,
    output logic                               busy
);

    localparam int unsigned CW = $clog2(MAX_OPS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_remaining;
    logic [WIDTH-1:0]  r_sum;
    logic [WIDTH-1:0]  r_carry;
    logic [WIDTH-1:0]  r_total;
    logic              r_op_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic              w_op_ready_nxt;
    logic              w_out_valid_nxt;
    logic              w_busy_nxt;
    logic              w_accept;
    logic              w_last;
    logic [CW-1:0]     w_num_clamped;
    logic [WIDTH-1:0]  w_s;
    logic [WIDTH-1:0]  w_c;
    logic [WIDTH-1:0]  w_carry_sh;
    logic [WIDTH-1:0]  w_total;

    // One compressor row; the carry out of the MSB is dropped by the shift.
    assign w_s        = r_sum ^ r_carry ^ op_data;
    assign w_c        = (r_sum & r_carry) | (r_sum & op_data) | (r_carry & op_data);
    assign w_carry_sh = {w_c[WIDTH-2:0], 1'b0};
    assign w_total    = w_s + w_carry_sh;

    assign w_accept      = (r_state == S_ACCUM) && op_valid;
    assign w_last        = (r_remaining == CW'(1));
    assign w_num_clamped = (num_ops > CW'(MAX_OPS)) ? CW'(MAX_OPS) : num_ops;

    // State and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op_ready  <= w_op_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_num_clamped == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control outputs are decoded from the upcoming state so they leave a flop.
    always_comb begin
        w_op_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        case (w_state_nxt)
            S_ACCUM: begin
                w_op_ready_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
            end
            S_DONE: begin
                w_out_valid_nxt = 1'b1;
                w_busy_nxt      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
            r_sum       <= '0;
            r_carry     <= '0;
            r_total     <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_remaining <= w_num_clamped;
            r_sum       <= '0;
            r_carry     <= '0;
            r_total     <= '0;
        end else if (w_accept) begin
            r_remaining <= r_remaining - CW'(1);
            r_sum       <= w_s;
            r_carry     <= w_carry_sh;
            if (w_last) begin
                r_total <= w_total;
            end
        end
    end

    assign op_ready  = r_op_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_sum   = r_sum;
    assign out_carry = r_carry;
    assign out_total = r_total;

endmodule
